regfile: RTL and testbench

Architectural general-purpose register file for the five-stage integer pipeline. It is the receiving end of the write-back triple (destination address, write enable, result data) that the execute stage produces and the pipeline carries through memory to write-back. It also supplies the two source operands that the decode stage forwards as reg1/reg2. It has 32 × 32-bit registers, one synchronous write port, two combinational read ports, and same-cycle write-to-read bypass.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile.sv | 71 +++++++
 tb/tb_regfile.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants: bus widths, register count and control encodings.
// Parameter defaults of the register file derive from these.
package regfile_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;
  localparam int unsigned RegNumLog2 = 5;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;

  localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile.sv
// Architectural register file: 32 x 32-bit, one synchronous write port, two
// combinational read ports with same-cycle write-to-read bypass; r0 reads as zero.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RegBus,
  parameter int unsigned ADDR_W   = RegNumLog2,
  parameter int unsigned NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_stored1;
  logic [DATA_W-1:0] w_stored2;

  // Reset wins over a concurrent write; address 0 is never written.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we == WriteEnable && waddr != '0) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Read priority: reset, disabled port, r0, in-flight write, then storage.
  function automatic logic [DATA_W-1:0] f_read_port(
    input logic              i_rst,
    input logic              i_re,
    input logic [ADDR_W-1:0] i_raddr,
    input logic              i_we,
    input logic [ADDR_W-1:0] i_waddr,
    input logic [DATA_W-1:0] i_wdata,
    input logic [DATA_W-1:0] i_stored
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (i_rst == RstEnable) begin
      v = '0;
    end else if (i_re != ReadEnable) begin
      v = '0;
    end else if (i_raddr == '0) begin
      v = '0;
    end else if (i_we == WriteEnable && i_waddr == i_raddr) begin
      v = i_wdata;
    end else begin
      v = i_stored;
    end
    return v;
  endfunction

  always_comb begin
    w_stored1 = r_regs[raddr1];
    w_stored2 = r_regs[raddr2];
    rdata1    = f_read_port(rst, re1, raddr1, we, waddr, wdata, w_stored1);
    rdata2    = f_read_port(rst, re2, raddr2, we, waddr, wdata, w_stored2);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based model.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [31:0] m_regs [32];

  regfile #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_REGS(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata2(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic e, input logic [4:0] a);
    if (rst) return 32'h0;
    if (!e) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  end

  // Architectural state update at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      m_regs[waddr] = wdata;
    end
  end

  always @(negedge clk) begin
    chk("model_p1", rdata1, model_read(re1, raddr1));
    chk("model_p2", rdata2, model_read(re2, raddr2));
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;

    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
    chk("rst_p1", rdata1, 32'h0);
    chk("rst_p2", rdata2, 32'h0);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
      chk("post_rst_p1", rdata1, 32'h0);
      chk("post_rst_p2", rdata2, 32'h0);
    end

    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
    chk("wr_r5", rdata1, 32'hDEADBEEF);
    chk("wr_r31", rdata2, 32'h12345678);

    drive(1'b0, 1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 1'b1, 5'd7);
    chk("byp_p1", rdata1, 32'hCAFEF00D);
    chk("byp_p2", rdata2, 32'hCAFEF00D);
    drive(1'b0, 1'b0, 5'd7, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    chk("byp_held_p1", rdata1, 32'hCAFEF00D);
    chk("byp_held_p2", rdata2, 32'hCAFEF00D);

    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0);
    chk("r0_same", rdata1, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
    chk("r0_later", rdata1, 32'h0);

    drive(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3);
    chk("re2_off", rdata2, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3);
    chk("re2_on", rdata2, 32'hA5A5A5A5);

    drive(1'b0, 1'b1, 5'd9, 32'h55AA55AA, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 1'b1, 5'd9, 32'h0BADCAFE, 1'b1, 5'd9, 1'b1, 5'd3);
    chk("rstwr_p1", rdata1, 32'h0);
    chk("rstwr_p2", rdata2, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd3);
    chk("rstwr_r9", rdata1, 32'h0);
    chk("rstwr_r3", rdata2, 32'h0);

    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wa;
      logic [4:0] a1;
      logic [4:0] a2;
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 63) == 0), 1'($urandom), wa, $urandom,
            ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2);
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
